// File: rtl/rf_pkg.sv
// rf_pkg: shared types and constants for the multi-port register file.
//   rf_clr_state_e - bulk-clear sequencer states
//   RF_*           - default width / depth / read-port count
//   port_lo()      - low bit of port k inside a packed per-port bus
package rf_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } rf_clr_state_e;

   localparam int RF_DATA_W = 8;
   localparam int RF_DEPTH  = 16;
   localparam int RF_NUM_RD = 2;

   function automatic int port_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// rf_multiport_if: read/write/clear bus of the multi-port register file.
//   master : operand-select / ALU side (drives enables, addresses, write data, clr_req)
//   slave  : register file side (drives rd_data, rd_valid, busy, clr_done, wr_err)
// Per-port fields are packed with port k at [k*W +: W].
interface rf_multiport_if import rf_pkg::*; #(
   parameter int DATA_W = RF_DATA_W,
   parameter int DEPTH  = RF_DEPTH,
   parameter int NUM_RD = RF_NUM_RD
);
   localparam int ADDR_W = $clog2(DEPTH);

   logic [NUM_RD-1:0]        rd_en;
   logic [NUM_RD*ADDR_W-1:0] rd_sel;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_valid;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_sel;
   logic [DATA_W-1:0]        data_in;
   logic                     clr_req;
   logic                     busy;
   logic                     clr_done;
   logic                     wr_err;

   modport master (
      output rd_en, rd_sel, wr_en, wr_sel, data_in, clr_req,
      input  rd_data, rd_valid, busy, clr_done, wr_err
   );

   modport slave (
      input  rd_en, rd_sel, wr_en, wr_sel, data_in, clr_req,
      output rd_data, rd_valid, busy, clr_done, wr_err
   );

endinterface

// File: rtl/rf_read_port.sv
// rf_read_port: one registered read port of rf_multiport.
//   clk, reset          - clock, synchronous active-high reset
//   rd_en, rd_sel       - read request for this port
//   busy                - bulk clear in progress (reads return 0)
//   wr_acc, wr_sel,
//   wr_data             - accepted write this cycle, used for write-first bypass
//   mem_flat            - flattened storage array, entry i at [i*DATA_W +: DATA_W]
//   rd_data, rd_valid   - registered result, one cycle after rd_en
module rf_read_port import rf_pkg::*; #(
   parameter  int DATA_W  = RF_DATA_W,
   parameter  int DEPTH   = RF_DEPTH,
   parameter  int ZERO_R0 = 0,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rd_en,
   input  logic [ADDR_W-1:0]       rd_sel,
   input  logic                    busy,
   input  logic                    wr_acc,
   input  logic [ADDR_W-1:0]       wr_sel,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [DEPTH*DATA_W-1:0] mem_flat,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_valid
);

   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] rd_data_d, rd_data_q;
   logic              rd_valid_d, rd_valid_q;

   // Priority: out of range, hardwired r0, clear in progress, bypass, storage.
   // The storage slice is only selected once the address is known in range.
   always_comb begin
      rd_word = '0;
      if (int'(rd_sel) >= DEPTH) begin
         rd_word = '0;
      end else if ((ZERO_R0 != 0) && (rd_sel == '0)) begin
         rd_word = '0;
      end else if (busy) begin
         rd_word = '0;
      end else if (wr_acc && (wr_sel == rd_sel)) begin
         rd_word = wr_data;
      end else begin
         rd_word = mem_flat[int'(rd_sel)*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      rd_data_d  = rd_en ? rd_word : rd_data_q;
      rd_valid_d = rd_en;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: DEPTH x DATA_W register file, NUM_RD registered read ports,
// one write port, optional hardwired-zero r0 and a one-register-per-cycle
// bulk-clear sequencer.
//   clk, reset - clock, synchronous active-high reset (clears array and sequencer)
//   bus        - rf_multiport_if slave: reads, write, clr_req, busy/clr_done/wr_err
module rf_multiport import rf_pkg::*; #(
   parameter  int DATA_W  = RF_DATA_W,
   parameter  int DEPTH   = RF_DEPTH,
   parameter  int NUM_RD  = RF_NUM_RD,
   parameter  int ZERO_R0 = 0,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   rf_multiport_if.slave bus
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0]       mem_d [DEPTH];
   logic [DATA_W-1:0]       mem_q [DEPTH];
   logic [DEPTH*DATA_W-1:0] mem_flat;

   rf_clr_state_e     state_q;
   logic [ADDR_W-1:0] idx_q;
   logic              busy_q;
   logic              clr_done_q;
   logic              wr_acc;
   logic              wr_err_d, wr_err_q;

   logic [DATA_W-1:0] rd_data_w  [NUM_RD];
   logic              rd_valid_w [NUM_RD];

   // A write is refused while clearing, when out of range, or aimed at a
   // hardwired r0; a refused write is reported one cycle later.
   always_comb begin
      wr_acc   = bus.wr_en && !busy_q && (int'(bus.wr_sel) < DEPTH) &&
                 !((ZERO_R0 != 0) && (bus.wr_sel == '0));
      wr_err_d = bus.wr_en && !wr_acc;
   end

   // Clearing and writing never coincide: writes are refused while busy.
   always_comb begin
      mem_d = mem_q;
      if (state_q == CLEAR) begin
         mem_d[idx_q] = '0;
      end
      if (wr_acc) begin
         mem_d[bus.wr_sel] = bus.data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_err_q <= 1'b0;
      end else begin
         mem_q    <= mem_d;
         wr_err_q <= wr_err_d;
      end
   end

   // Bulk-clear sequencer; clr_req while CLEAR is ignored.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         busy_q     <= 1'b0;
         clr_done_q <= 1'b0;
      end else begin
         clr_done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.clr_req) begin
                  state_q <= CLEAR;
                  idx_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            CLEAR: begin
               if (idx_q == LAST_IDX) begin
                  state_q    <= IDLE;
                  idx_q      <= '0;
                  busy_q     <= 1'b0;
                  clr_done_q <= 1'b1;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      mem_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem_flat[i*DATA_W +: DATA_W] = mem_q[i];
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      localparam int SEL_LO = port_lo(k, ADDR_W);

      rf_read_port #(
         .DATA_W  (DATA_W),
         .DEPTH   (DEPTH),
         .ZERO_R0 (ZERO_R0)
      ) u_port (
         .clk      (clk),
         .reset    (reset),
         .rd_en    (bus.rd_en[k]),
         .rd_sel   (bus.rd_sel[SEL_LO +: ADDR_W]),
         .busy     (busy_q),
         .wr_acc   (wr_acc),
         .wr_sel   (bus.wr_sel),
         .wr_data  (bus.data_in),
         .mem_flat (mem_flat),
         .rd_data  (rd_data_w[k]),
         .rd_valid (rd_valid_w[k])
      );
   end

   always_comb begin
      bus.rd_data  = '0;
      bus.rd_valid = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         bus.rd_data[k*DATA_W +: DATA_W] = rd_data_w[k];
         bus.rd_valid[k]                 = rd_valid_w[k];
      end
   end

   assign bus.busy     = busy_q;
   assign bus.clr_done = clr_done_q;
   assign bus.wr_err   = wr_err_q;

endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: scoreboard bench for rf_multiport.
//   DUT A: DEPTH=16, ZERO_R0=0.  DUT B: DEPTH=12, ZERO_R0=1.
// Stimulus computes the expected outputs of every cycle from a behavioural
// model and queues them; a monitor pops and compares after each clock edge.
module tb_rf_multiport;

   typedef struct packed {
      logic            reset;
      logic [1:0]      rd_en;
      logic [1:0][3:0] rd_sel;
      logic            wr_en;
      logic [3:0]      wr_sel;
      logic [7:0]      din;
      logic            clr;
   } stim_t;

   typedef struct packed {
      logic [1:0][7:0] rd_data;
      logic [1:0]      rd_valid;
      logic            busy;
      logic            clr_done;
      logic            wr_err;
   } exp_t;

   typedef struct packed {
      logic [15:0][7:0] mem;
      int               clr_left;
      logic [1:0][7:0]  last;
   } model_t;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;
   always #5 clk = ~clk;

   rf_multiport_if #(.DATA_W(8), .DEPTH(16), .NUM_RD(2)) bus_a ();
   rf_multiport_if #(.DATA_W(8), .DEPTH(12), .NUM_RD(2)) bus_b ();

   rf_multiport #(.DATA_W(8), .DEPTH(16), .NUM_RD(2), .ZERO_R0(0)) dut_a (
      .clk   (clk),
      .reset (rst_a),
      .bus   (bus_a.slave)
   );

   rf_multiport #(.DATA_W(8), .DEPTH(12), .NUM_RD(2), .ZERO_R0(1)) dut_b (
      .clk   (clk),
      .reset (rst_b),
      .bus   (bus_b.slave)
   );

   exp_t   qa[$];
   exp_t   qb[$];
   model_t ma, mb;
   int     checks = 0;
   int     errors = 0;

   // Behavioural model: state is the register contents, the number of
   // registers still to be swept, and each port's last returned value.
   function automatic void model_step(input model_t mi, input stim_t s, input int depth,
                                      input bit z, output model_t mo, output exp_t e);
      bit busy, wr_ok;
      int a;
      logic [7:0] v;
      mo = mi;
      e  = '0;
      if (s.reset) begin
         mo = '0;
      end else begin
         busy  = (mi.clr_left > 0);
         wr_ok = s.wr_en && (int'(s.wr_sel) < depth) && !(z && s.wr_sel == 4'd0) && !busy;
         for (int k = 0; k < 2; k++) begin
            if (s.rd_en[k]) begin
               a = int'(s.rd_sel[k]);
               if (a >= depth || (z && a == 0) || busy) v = 8'h00;
               else if (wr_ok && int'(s.wr_sel) == a)   v = s.din;
               else                                      v = mi.mem[a];
               mo.last[k] = v;
            end
         end
         e.rd_data  = mo.last;
         e.rd_valid = s.rd_en;
         e.wr_err   = s.wr_en && !wr_ok;
         if (busy) begin
            mo.mem[depth - mi.clr_left] = 8'h00;
            mo.clr_left = mi.clr_left - 1;
            e.clr_done  = (mo.clr_left == 0);
         end else if (s.clr) begin
            mo.clr_left = depth;
         end
         e.busy = (mo.clr_left > 0);
         if (wr_ok) mo.mem[s.wr_sel] = s.din;
      end
   endfunction

   task automatic step(input bit which, input bit r, input logic [1:0] ren,
                       input logic [3:0] s0, input logic [3:0] s1, input bit wen,
                       input logic [3:0] ws, input logic [7:0] d, input bit clr);
      stim_t  s;
      exp_t   e;
      model_t m;
      @(negedge clk);
      s.reset     = r;
      s.rd_en     = ren;
      s.rd_sel[0] = s0;
      s.rd_sel[1] = s1;
      s.wr_en     = wen;
      s.wr_sel    = ws;
      s.din       = d;
      s.clr       = clr;
      if (!which) begin
         rst_a = r; bus_a.rd_en = ren; bus_a.rd_sel = {s1, s0};
         bus_a.wr_en = wen; bus_a.wr_sel = ws; bus_a.data_in = d; bus_a.clr_req = clr;
         model_step(ma, s, 16, 1'b0, m, e);
         ma = m;
         qa.push_back(e);
      end else begin
         rst_b = r; bus_b.rd_en = ren; bus_b.rd_sel = {s1, s0};
         bus_b.wr_en = wen; bus_b.wr_sel = ws; bus_b.data_in = d; bus_b.clr_req = clr;
         model_step(mb, s, 12, 1'b1, m, e);
         mb = m;
         qb.push_back(e);
      end
   endtask

   task automatic idle(input bit which, input int n);
      for (int i = 0; i < n; i++) step(which, 0, 2'b00, 0, 0, 0, 0, 8'h00, 0);
   endtask

   task automatic rd(input bit which, input logic [3:0] s0, input logic [3:0] s1);
      step(which, 0, 2'b11, s0, s1, 0, 0, 8'h00, 0);
   endtask

   task automatic wr(input bit which, input logic [3:0] ws, input logic [7:0] d);
      step(which, 0, 2'b00, 0, 0, 1, ws, d, 0);
   endtask

   task automatic rand_steps(input bit which, input int n);
      for (int i = 0; i < n; i++) begin
         step(which, ($urandom_range(0, 99) == 0), 2'($urandom), 4'($urandom), 4'($urandom),
              1'($urandom), 4'($urandom), 8'($urandom), ($urandom_range(0, 29) == 0));
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare(input string tag, input exp_t e, input logic [15:0] rdata,
                          input logic [1:0] rvalid, input logic busy, input logic done,
                          input logic werr);
      chk({tag, " rd_valid"}, 32'(rvalid), 32'(e.rd_valid));
      chk({tag, " rd_data0"}, 32'(rdata[7:0]), 32'(e.rd_data[0]));
      chk({tag, " rd_data1"}, 32'(rdata[15:8]), 32'(e.rd_data[1]));
      chk({tag, " busy"}, 32'(busy), 32'(e.busy));
      chk({tag, " clr_done"}, 32'(done), 32'(e.clr_done));
      chk({tag, " wr_err"}, 32'(werr), 32'(e.wr_err));
   endtask

   // Monitor: one expected entry per clock edge, checked 1 time unit later.
   always @(posedge clk) begin
      #1;
      if (qa.size() > 0) begin
         compare("A", qa.pop_front(), bus_a.rd_data, bus_a.rd_valid, bus_a.busy,
                 bus_a.clr_done, bus_a.wr_err);
      end
      if (qb.size() > 0) begin
         compare("B", qb.pop_front(), bus_b.rd_data, bus_b.rd_valid, bus_b.busy,
                 bus_b.clr_done, bus_b.wr_err);
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      ma = '0;
      mb = '0;
      bus_a.rd_en = '0; bus_a.rd_sel = '0; bus_a.wr_en = 0; bus_a.wr_sel = '0;
      bus_a.data_in = '0; bus_a.clr_req = 0;
      bus_b.rd_en = '0; bus_b.rd_sel = '0; bus_b.wr_en = 0; bus_b.wr_sel = '0;
      bus_b.data_in = '0; bus_b.clr_req = 0;

      // DUT A: reset, then read r5/r15
      step(0, 1, 2'b00, 0, 0, 0, 0, 8'h00, 0);
      rd(0, 4'd5, 4'd15);
      // write then read on both ports
      wr(0, 4'd3, 8'hA5);
      rd(0, 4'd3, 4'd3);
      // bypass on port 0, stored value on port 1
      wr(0, 4'd6, 8'h66);
      step(0, 0, 2'b11, 4'd7, 4'd6, 1, 4'd7, 8'h3C, 0);
      step(0, 0, 2'b00, 4'd1, 4'd2, 0, 0, 8'h00, 0);
      rd(0, 4'd7, 4'd3);
      // fill, then clear with a dropped write and an ignored second clr_req
      for (int i = 0; i < 16; i++) wr(0, 4'(i), 8'(8'h10 + i));
      step(0, 0, 2'b00, 0, 0, 0, 0, 8'h00, 1);
      for (int c = 1; c <= 17; c++) begin
         step(0, 0, 2'b11, 4'(c), 4'd2, (c == 2), 4'd2, 8'h77, (c == 4));
      end
      for (int i = 0; i < 8; i++) rd(0, 4'(2*i), 4'(2*i + 1));
      // write accepted in the same idle cycle as clr_req is swept
      step(0, 0, 2'b00, 0, 0, 1, 4'd9, 8'h99, 1);
      idle(0, 17);
      rd(0, 4'd9, 4'd9);
      // reset in the middle of a clear, then a fresh clear
      for (int i = 0; i < 16; i++) wr(0, 4'(i), 8'(8'h40 + i));
      step(0, 0, 2'b00, 0, 0, 0, 0, 8'h00, 1);
      idle(0, 5);
      step(0, 1, 2'b00, 0, 0, 0, 0, 8'h00, 0);
      idle(0, 2);
      for (int i = 0; i < 8; i++) rd(0, 4'(2*i), 4'(2*i + 1));
      wr(0, 4'd4, 8'hC4);
      step(0, 0, 2'b00, 0, 0, 0, 0, 8'h00, 1);
      idle(0, 17);
      rd(0, 4'd4, 4'd0);
      rand_steps(0, 400);
      idle(0, 2);

      // DUT B: DEPTH=12, r0 hardwired to zero
      step(1, 1, 2'b00, 0, 0, 0, 0, 8'h00, 0);
      wr(1, 4'd0, 8'hFF);
      rd(1, 4'd0, 4'd0);
      wr(1, 4'd13, 8'h55);
      rd(1, 4'd13, 4'd12);
      wr(1, 4'd11, 8'hAB);
      rd(1, 4'd11, 4'd0);
      step(1, 0, 2'b11, 4'd5, 4'd0, 1, 4'd5, 8'h5A, 0);
      step(1, 0, 2'b00, 0, 0, 0, 0, 8'h00, 1);
      idle(1, 13);
      rd(1, 4'd11, 4'd5);
      rand_steps(1, 300);
      idle(1, 2);

      for (int i = 0; i < 20 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clk);
      #2;
      chk("queues drained", 32'(qa.size() + qb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
